// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

   localparam int          PC_W      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // IF/ID pipeline register contents
   typedef struct packed {
      logic [PC_W-1:0] instr;
      logic [PC_W-1:0] pc;
      logic            valid;
   } ifid_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {data, pc} buffer that parks a fetched word while decode is frozen.
module fetch_hold_buffer
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [PC_W-1:0] load_data,
   input  logic [PC_W-1:0] load_pc,
   output logic [PC_W-1:0] data,
   output logic [PC_W-1:0] pc,
   output logic            full
);

   // clear wins over load so a redirect always drops a parked word
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         data <= '0;
         pc   <= '0;
         full <= 1'b0;
      end else if (load) begin
         data <= load_data;
         pc   <= load_pc;
         full <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency imem and
// loads the IF/ID register, inserting NOP bubbles on waits and redirects.
module if_stage_fetch
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            Br_taken,
   input  logic [PC_W-1:0] branch_addr,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [PC_W-1:0] imem_rdata,
   output logic [PC_W-1:0] instruction,
   output logic [PC_W-1:0] PC,
   output logic            instr_valid
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] req_addr;
   logic            req_q;
   ifid_t           ifid;

   logic            buf_load;
   logic            buf_clear;
   logic            buf_full;
   logic [PC_W-1:0] buf_data;
   logic [PC_W-1:0] buf_pc;

   assign pc_inc = pc + PC_STEP;

   // park an accepted word when decode is frozen; drop it on redirect or release
   always_comb begin
      buf_load  = (state == FETCH) && req_q && imem_ready && freeze && !Br_taken;
      buf_clear = Br_taken || ((state == HOLD) && !freeze);
   end

   fetch_hold_buffer u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .clear     (buf_clear),
      .load_data (imem_rdata),
      .load_pc   (pc_inc),
      .data      (buf_data),
      .pc        (buf_pc),
      .full      (buf_full)
   );

   // PC, request and IF/ID sequencing; req_q is low only right after reset
   // and in HOLD, so a ready strobe is never taken without an open request
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         req_q    <= 1'b0;
         state    <= FETCH;
         ifid     <= '0;
      end else if (Br_taken) begin
         pc          <= branch_addr;
         ifid.instr  <= NOP_INSTR;
         ifid.valid  <= 1'b0;
         // an open request must be drained before the target can be issued
         if ((state == FETCH && req_q && !imem_ready) || state == DRAIN) begin
            state <= DRAIN;
         end else begin
            state    <= FETCH;
            req_q    <= 1'b1;
            req_addr <= branch_addr;
         end
      end else begin
         case (state)
            FETCH: begin
               if (!req_q) begin
                  req_q    <= 1'b1;
                  req_addr <= pc;
               end else if (imem_ready) begin
                  pc <= pc_inc;
                  if (!freeze) begin
                     ifid     <= {imem_rdata, pc_inc, 1'b1};
                     req_addr <= pc_inc;
                  end else begin
                     state <= HOLD;
                     req_q <= 1'b0;
                  end
               end else if (!freeze) begin
                  ifid.instr <= NOP_INSTR;
                  ifid.valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!freeze) begin
                  ifid     <= {buf_data, buf_pc, buf_full};
                  state    <= FETCH;
                  req_q    <= 1'b1;
                  req_addr <= pc;
               end
            end
            DRAIN: begin
               ifid.instr <= NOP_INSTR;
               ifid.valid <= 1'b0;
               if (imem_ready) begin
                  state    <= FETCH;
                  req_addr <= pc;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = req_addr;
   assign instruction = ifid.instr;
   assign PC          = ifid.pc;
   assign instr_valid = ifid.valid;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios followed by random traffic,
// all checked against a program-order model of the delivered instruction stream.
module tb_if_stage_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        Br_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] PC;
   logic        instr_valid;

   int          checks    = 0;
   int          failures  = 0;
   int          delivered = 0;
   logic [31:0] exp_next  = RESET_PC;

   if_stage_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .Br_taken    (Br_taken),
      .branch_addr (branch_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .PC          (PC),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   // memory image: the word stored at address a is a + 0x100
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: capture what the edge sees, then check the result against
   // the stream model (next program-order address, redirect, freeze, reset)
   task automatic cyc();
      logic        s_rst, s_frz, s_br, s_rdy;
      logic [31:0] s_baddr, p_instr, p_pc, p_addr;
      logic        p_valid, p_req;
      s_rst = rst; s_frz = freeze; s_br = Br_taken; s_rdy = imem_ready; s_baddr = branch_addr;
      p_instr = instruction; p_pc = PC; p_valid = instr_valid; p_req = imem_req; p_addr = imem_addr;
      @(posedge clk);
      #1;
      if (!s_rst) begin
         chk("rst_instr", instruction, 32'h0);
         chk("rst_pc", PC, 32'h0);
         chk("rst_valid", {31'h0, instr_valid}, 32'h0);
         chk("rst_req", {31'h0, imem_req}, 32'h0);
         chk("rst_addr", imem_addr, RESET_PC);
         exp_next = RESET_PC;
      end else if (s_br) begin
         chk("br_valid", {31'h0, instr_valid}, 32'h0);
         chk("br_instr", instruction, 32'h0);
         exp_next = s_baddr;
      end else if (s_frz) begin
         chk("frz_instr", instruction, p_instr);
         chk("frz_pc", PC, p_pc);
         chk("frz_valid", {31'h0, instr_valid}, {31'h0, p_valid});
      end else if (instr_valid === 1'b1) begin
         chk("instr", instruction, mem_word(exp_next));
         chk("pc", PC, exp_next + PC_STEP);
         exp_next = exp_next + PC_STEP;
         delivered++;
      end else begin
         chk("bub_instr", instruction, 32'h0);
         chk("bub_pc", PC, p_pc);
      end
      if (s_rst && p_req === 1'b1 && !s_rdy) begin
         chk("addr_stable", imem_addr, p_addr);
         chk("req_stable", {31'h0, imem_req}, 32'h1);
      end
      imem_rdata = mem_word(imem_addr);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; freeze = 1'b0; Br_taken = 1'b0; branch_addr = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      cyc(); cyc();

      // first request comes the cycle after reset release
      rst = 1'b1;
      cyc();
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);

      // zero-wait stream
      imem_ready = 1'b1;
      cyc();
      chk("zw_addr4", imem_addr, 32'h4);
      chk("zw_instr0", instruction, 32'h100);
      chk("zw_pc0", PC, 32'h4);
      cyc();
      chk("zw_addr8", imem_addr, 32'h8);
      chk("zw_instr1", instruction, 32'h104);

      // three wait states at address 8
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wait_valid", {31'h0, instr_valid}, 32'h0);
         chk("wait_addr", imem_addr, 32'h8);
      end
      imem_ready = 1'b1;
      cyc();
      chk("wait_instr", instruction, 32'h108);
      chk("wait_pc", PC, 32'hC);

      // freeze while word 12 returns
      freeze = 1'b1;
      cyc();
      chk("frz_req0", {31'h0, imem_req}, 32'h0);
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("frz_hold", instruction, 32'h108);
         chk("frz_req", {31'h0, imem_req}, 32'h0);
      end
      freeze = 1'b0;
      cyc();
      chk("rel_instr", instruction, 32'h10C);
      chk("rel_pc", PC, 32'h10);
      chk("rel_addr", imem_addr, 32'h10);
      chk("rel_req", {31'h0, imem_req}, 32'h1);

      // taken branch with zero-wait memory
      imem_ready = 1'b1; Br_taken = 1'b1; branch_addr = 32'h40;
      cyc();
      chk("br_bubble", {31'h0, instr_valid}, 32'h0);
      chk("br_addr", imem_addr, 32'h40);
      Br_taken = 1'b0;
      cyc();
      chk("br_tgt_instr", instruction, 32'h140);
      chk("br_tgt_pc", PC, 32'h44);

      // redirect while the fetch at 20 is outstanding
      Br_taken = 1'b1; branch_addr = 32'h14;
      cyc();
      Br_taken = 1'b0; imem_ready = 1'b0;
      cyc();
      Br_taken = 1'b1; branch_addr = 32'h40;
      cyc();
      chk("drain_addr", imem_addr, 32'h14);
      Br_taken = 1'b0;
      cyc();
      chk("drain_addr2", imem_addr, 32'h14);
      imem_ready = 1'b1;
      cyc();
      chk("drain_valid", {31'h0, instr_valid}, 32'h0);
      chk("drain_next", imem_addr, 32'h40);
      cyc();
      chk("drain_tgt", instruction, 32'h140);

      // reset in the middle of a drain
      imem_ready = 1'b0; Br_taken = 1'b1; branch_addr = 32'h40;
      cyc();
      Br_taken = 1'b0; rst = 1'b0;
      cyc();
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
      rst = 1'b1;
      cyc();
      imem_ready = 1'b1;
      cyc();
      chk("post_rst_instr", instruction, 32'h100);

      // PC wrap at the top of the address space
      Br_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      cyc();
      Br_taken = 1'b0;
      cyc();
      chk("wrap_instr", instruction, 32'h0000_00FC);
      chk("wrap_pc", PC, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);

      // random traffic
      delivered = 0;
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 299) != 0);
         freeze      = ($urandom_range(0, 4) == 0);
         Br_taken    = ($urandom_range(0, 9) == 0);
         branch_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         imem_ready  = imem_req && ($urandom_range(0, 2) != 0);
         cyc();
      end
      chk("progress", {31'h0, (delivered > 200)}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
